mem_io_bridge: RTL and testbench

- Sits directly downstream of the CPU memory master port and consumes its Avalon-style requests (address, rd, wr, wrdata).
- Returns wait, rddata and rddatavalid to the CPU.
- Decodes each request to one of three targets: an on-chip synchronous RAM (1-cycle read latency), a 16-word I/O peripheral region with a waitrequest handshake, or unmapped space.
- All CPU request/response timing for the system is generated here.

---
 rtl/mem_io_pkg.sv | 35 +++
 rtl/mem_io_decode.sv | 34 +++
 rtl/mem_io_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_mem_io_bridge.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared types and constants for the CPU memory/I-O bridge.
// Contents: widths, FSM state enum, decode target enum, capture payload
// struct and the fixed read-data values returned for unmapped and
// timed-out reads.
package mem_io_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned IO_IDX_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAM_RD = 2'd1,
        IO_ACC = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM  = 2'd0,
        TGT_IO   = 2'd1,
        TGT_NONE = 2'd2
    } target_t;

    // Request fields held across a multi-cycle access
    typedef struct packed {
        logic [IO_IDX_W-1:0] addr;
        logic [DATA_W-1:0]   wrdata;
        logic                wr;
        target_t             tgt;
    } capture_t;

    localparam logic [DATA_W-1:0] UNMAPPED_RDATA = 16'h0000;
    localparam logic [DATA_W-1:0] TIMEOUT_RDATA  = 16'hDEAD;

endpackage

// File: rtl/mem_io_decode.sv
// Combinational address decoder: classifies a CPU word address as RAM,
// I/O or unmapped.
// Ports:
//   addr : CPU word address
//   tgt  : decoded target (TGT_RAM / TGT_IO / TGT_NONE)
// Parameters: RAM_AW (RAM hit below 2**RAM_AW), IO_BASE (16-word I/O block).
module mem_io_decode
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_AW  = 12,
    parameter logic [15:0] IO_BASE = 16'hFF00
) (
    input  logic [ADDR_W-1:0] addr,
    output target_t           tgt
);

    localparam logic [31:0] RAM_END = 32'd1 << RAM_AW;
    localparam logic [31:0] IO_LO   = 32'({IO_BASE[15:4], 4'h0});

    // RAM must end at or below the start of the I/O block
    if (RAM_AW >= ADDR_W || IO_LO < RAM_END) begin : g_overlap_chk
        $error("mem_io_decode: RAM region overlaps the I/O region");
    end

    always_comb begin
        tgt = TGT_NONE;
        if (addr[15:4] == IO_BASE[15:4]) begin
            tgt = TGT_IO;
        end else if (32'(addr) < RAM_END) begin
            tgt = TGT_RAM;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory-port bridge: accepts Avalon-style requests and routes them to
// a 1-cycle-latency synchronous RAM, a 16-word I/O block with waitrequest,
// or unmapped space (writes dropped, reads return zero).
// Ports:
//   clk, reset (async, active low)
//   CPU side : i_cpu_addr, i_cpu_rd, i_cpu_wr, i_cpu_wrdata,
//              o_cpu_rddata, o_cpu_wait, o_cpu_rddatavalid
//   RAM side : o_ram_addr, o_ram_wr, o_ram_wrdata, i_ram_rddata
//   I/O side : o_io_addr, o_io_rd, o_io_wr, o_io_wrdata, i_io_rddata, i_io_wait
//   o_bus_err: sticky I/O timeout flag
// Build option: define IO_TIMEOUT_EN to abort I/O accesses that wait
// TIMEOUT_CYC consecutive cycles; otherwise I/O waits indefinitely and
// o_bus_err is tied low.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_AW      = 12,
    parameter logic [15:0] IO_BASE     = 16'hFF00,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       i_cpu_addr,
    input  logic              i_cpu_rd,
    input  logic              i_cpu_wr,
    input  logic [15:0]       i_cpu_wrdata,
    output logic [15:0]       o_cpu_rddata,
    output logic              o_cpu_wait,
    output logic              o_cpu_rddatavalid,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_wr,
    output logic [15:0]       o_ram_wrdata,
    input  logic [15:0]       i_ram_rddata,
    output logic [3:0]        o_io_addr,
    output logic              o_io_rd,
    output logic              o_io_wr,
    output logic [15:0]       o_io_wrdata,
    input  logic [15:0]       i_io_rddata,
    input  logic              i_io_wait,
    output logic              o_bus_err
);

    if (TIMEOUT_CYC < 1) begin : g_timeout_chk
        $error("mem_io_bridge: TIMEOUT_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    capture_t          cap_q, cap_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    target_t           req_tgt;
    logic              req_wr;
    logic              req_rd;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    mem_io_decode #(
        .RAM_AW  (RAM_AW),
        .IO_BASE (IO_BASE)
    ) u_decode (
        .addr (i_cpu_addr),
        .tgt  (req_tgt)
    );

    // rd together with wr is a write
    assign req_wr     = i_cpu_wr;
    assign req_rd     = i_cpu_rd & ~i_cpu_wr;
    assign o_cpu_wait = (state_q != IDLE);

`ifdef IO_TIMEOUT_EN
    assign o_bus_err = bus_err_q;
`else
    assign o_bus_err = 1'b0;
`endif

    // State, capture and timeout registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cap_q     <= '0;
            rdata_q   <= '0;
`ifdef IO_TIMEOUT_EN
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cap_q     <= cap_d;
            rdata_q   <= rdata_d;
`ifdef IO_TIMEOUT_EN
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
`endif
        end
    end

    // Next-state, capture and bus-strobe logic
    always_comb begin
        state_d           = state_q;
        cap_d             = cap_q;
        rdata_d           = rdata_q;
`ifdef IO_TIMEOUT_EN
        cnt_d             = cnt_q;
        bus_err_d         = bus_err_q;
`endif
        o_cpu_rddata      = '0;
        o_cpu_rddatavalid = 1'b0;
        o_ram_addr        = '0;
        o_ram_wr          = 1'b0;
        o_ram_wrdata      = '0;
        o_io_addr         = '0;
        o_io_rd           = 1'b0;
        o_io_wr           = 1'b0;
        o_io_wrdata       = '0;

        case (state_q)
            IDLE: begin
                if (req_rd || req_wr) begin
                    cap_d.addr   = i_cpu_addr[IO_IDX_W-1:0];
                    cap_d.wrdata = i_cpu_wrdata;
                    cap_d.wr     = req_wr;
                    cap_d.tgt    = req_tgt;
                    case (req_tgt)
                        TGT_RAM: begin
                            // RAM writes complete in the accepting cycle
                            o_ram_addr = i_cpu_addr[RAM_AW-1:0];
                            if (req_wr) begin
                                o_ram_wr     = 1'b1;
                                o_ram_wrdata = i_cpu_wrdata;
                            end else begin
                                state_d = RAM_RD;
                            end
                        end
                        TGT_IO: begin
                            state_d = IO_ACC;
`ifdef IO_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                        default: begin
                            if (!req_wr) begin
                                rdata_d = UNMAPPED_RDATA;
                                state_d = RESP;
                            end
                        end
                    endcase
                end
            end

            RAM_RD: begin
                o_cpu_rddatavalid = 1'b1;
                o_cpu_rddata      = i_ram_rddata;
                state_d           = IDLE;
            end

            IO_ACC: begin
                o_io_addr   = cap_q.addr;
                o_io_rd     = ~cap_q.wr & (cap_q.tgt == TGT_IO);
                o_io_wr     = cap_q.wr & (cap_q.tgt == TGT_IO);
                o_io_wrdata = cap_q.wr ? cap_q.wrdata : '0;
                if (!i_io_wait) begin
                    if (cap_q.wr) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = i_io_rddata;
                        state_d = RESP;
                    end
                end
`ifdef IO_TIMEOUT_EN
                // Abort on the TIMEOUT_CYC-th consecutive wait cycle
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    bus_err_d = 1'b1;
                    if (cap_q.wr) begin
                        state_d = IDLE;
                    end else begin
                        rdata_d = TIMEOUT_RDATA;
                        state_d = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end

            RESP: begin
                o_cpu_rddatavalid = 1'b1;
                o_cpu_rddata      = rdata_q;
                state_d           = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: a driver issues directed and random
// CPU requests, a reference model (plain arrays + address rules) predicts
// each read response and its cycle, and a monitor compares on every
// o_cpu_rddatavalid. RAM and I/O slaves are simple behavioural models.
module tb_mem_io_bridge;

    localparam int unsigned RAM_AW = 12;
    localparam int unsigned T_CYC  = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [15:0]       i_cpu_addr = '0;
    logic              i_cpu_rd = 1'b0;
    logic              i_cpu_wr = 1'b0;
    logic [15:0]       i_cpu_wrdata = '0;
    logic [15:0]       o_cpu_rddata;
    logic              o_cpu_wait;
    logic              o_cpu_rddatavalid;
    logic [RAM_AW-1:0] o_ram_addr;
    logic              o_ram_wr;
    logic [15:0]       o_ram_wrdata;
    logic [15:0]       i_ram_rddata;
    logic [3:0]        o_io_addr;
    logic              o_io_rd;
    logic              o_io_wr;
    logic [15:0]       o_io_wrdata;
    logic [15:0]       i_io_rddata;
    logic              i_io_wait;
    logic              o_bus_err;

    mem_io_bridge #(
        .RAM_AW      (RAM_AW),
        .IO_BASE     (16'hFF00),
        .TIMEOUT_CYC (T_CYC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .i_cpu_addr        (i_cpu_addr),
        .i_cpu_rd          (i_cpu_rd),
        .i_cpu_wr          (i_cpu_wr),
        .i_cpu_wrdata      (i_cpu_wrdata),
        .o_cpu_rddata      (o_cpu_rddata),
        .o_cpu_wait        (o_cpu_wait),
        .o_cpu_rddatavalid (o_cpu_rddatavalid),
        .o_ram_addr        (o_ram_addr),
        .o_ram_wr          (o_ram_wr),
        .o_ram_wrdata      (o_ram_wrdata),
        .i_ram_rddata      (i_ram_rddata),
        .o_io_addr         (o_io_addr),
        .o_io_rd           (o_io_rd),
        .o_io_wr           (o_io_wr),
        .o_io_wrdata       (o_io_wrdata),
        .i_io_rddata       (i_io_rddata),
        .i_io_wait         (i_io_wait),
        .o_bus_err         (o_bus_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Synchronous RAM slave, one cycle read latency
    logic [15:0] ram_mem [0:4095];
    logic [15:0] ram_rd_q = '0;
    always @(posedge clk) begin
        if (o_ram_wr) ram_mem[o_ram_addr] <= o_ram_wrdata;
        ram_rd_q <= ram_mem[o_ram_addr];
    end
    assign i_ram_rddata = ram_rd_q;

    // I/O slave: holds wait for io_lat cycles of each strobe
    logic [15:0] io_regs [0:15];
    int io_lat = 0;
    int io_cycles = 0;
    always @(posedge clk) begin
        if (o_io_rd || o_io_wr) io_cycles <= io_cycles + 1;
        else                    io_cycles <= 0;
        if (o_io_wr && !i_io_wait) io_regs[o_io_addr] <= o_io_wrdata;
    end
    assign i_io_wait   = (o_io_rd || o_io_wr) && (io_cycles < io_lat);
    assign i_io_rddata = (o_io_rd && !i_io_wait) ? io_regs[o_io_addr] : 16'h0000;

    // Reference model state and scoreboard
    typedef struct {
        logic [15:0] data;
        int unsigned cyc;
    } exp_t;
    exp_t        sb_q[$];
    logic [15:0] ref_ram [0:4095];
    logic [15:0] ref_io  [0:15];
    logic [15:0] unm_tab [0:6] = '{16'h1000, 16'h1005, 16'h1FFF, 16'h8000,
                                   16'hFEFF, 16'hFF10, 16'hFFFF};

    // 0 = RAM, 1 = I/O, 2 = unmapped
    function automatic int classify(input logic [15:0] a);
        if (a >= 16'hFF00 && a <= 16'hFF0F) return 1;
        if (a < 16'h1000) return 0;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic logic any_output();
        return |{o_cpu_rddata, o_cpu_wait, o_cpu_rddatavalid, o_ram_addr, o_ram_wr,
                 o_ram_wrdata, o_io_addr, o_io_rd, o_io_wr, o_io_wrdata, o_bus_err};
    endfunction

    // Monitor: compare every presented read response against the scoreboard
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (o_cpu_rddatavalid) begin
                    chk("valid_with_wait", 32'(o_cpu_wait), 32'd1);
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: data 0x%0h at cycle %0d, none expected",
                                 o_cpu_rddata, cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk("rddata", 32'(o_cpu_rddata), 32'(e.data));
                        chk("rd_latency", cyc, e.cyc);
                    end
                end else begin
                    chk("rddata_zero_when_invalid", 32'(o_cpu_rddata), 32'd0);
                end
            end
        end
    end

    // Issue one request (called at posedge+1) and update the model
    task automatic do_req(input logic [15:0] addr, input logic rd, input logic wr,
                          input logic [15:0] data, input int lat);
        int          budget;
        int          tgt;
        int unsigned a;
        logic        aborted;
        exp_t        e;
        budget = 0;
        while (o_cpu_wait) begin
            @(posedge clk); #1;
            budget++;
            if (budget > 2000) begin
                checks++;
                errors++;
                $display("FAIL wait_timeout: o_cpu_wait stuck at 1, expected release");
                finish_sim();
            end
        end
        io_lat       = lat;
        i_cpu_addr   = addr;
        i_cpu_rd     = rd;
        i_cpu_wr     = wr;
        i_cpu_wrdata = data;
        tgt          = classify(addr);
        #1;
        chk("accept_no_wait", 32'(o_cpu_wait), 32'd0);
        chk("ram_wr_strobe", 32'(o_ram_wr), 32'(tgt == 0 && wr));
        if (tgt == 0) chk("ram_addr", 32'(o_ram_addr), 32'(addr[11:0]));
        if (tgt == 0 && wr) chk("ram_wrdata", 32'(o_ram_wrdata), 32'(data));
        chk("io_strobe_in_idle", 32'({o_io_rd, o_io_wr}), 32'd0);
        @(posedge clk); #1;
        a          = cyc;
        i_cpu_rd   = 1'b0;
        i_cpu_wr   = 1'b0;
        i_cpu_addr = 16'($urandom);
        i_cpu_wrdata = 16'($urandom);
        aborted = 1'b0;
`ifdef IO_TIMEOUT_EN
        aborted = (lat >= int'(T_CYC));
`endif
        case (tgt)
            0: begin
                if (wr) ref_ram[addr[11:0]] = data;
                else begin e.data = ref_ram[addr[11:0]]; e.cyc = a; sb_q.push_back(e); end
            end
            1: begin
                if (wr) begin
                    if (!aborted) ref_io[addr[3:0]] = data;
                end else if (aborted) begin
                    e.data = 16'hDEAD; e.cyc = a + T_CYC; sb_q.push_back(e);
                end else begin
                    e.data = ref_io[addr[3:0]]; e.cyc = a + 32'(lat) + 1; sb_q.push_back(e);
                end
            end
            default: begin
                if (!wr) begin e.data = 16'h0000; e.cyc = a; sb_q.push_back(e); end
            end
        endcase
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((sb_q.size() != 0 || o_cpu_wait) && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("drain_pending", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_sim();
    end

    // Driver
    initial begin
        logic [15:0] addr;
        int          r;
        int          k;
        #1;
        chk("reset_outputs_zero", 32'(any_output()), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        // Preload the RAM pool and all I/O registers
        for (int i = 0; i < 32; i++) begin
            addr = (i < 16) ? 16'(i) : 16'(4080 + i - 16);
            do_req(addr, 1'b0, 1'b1, 16'($urandom), 0);
        end
        for (int i = 0; i < 16; i++) do_req(16'hFF00 + 16'(i), 1'b0, 1'b1, 16'($urandom), i % 3);

        // RAM write then read back
        do_req(16'h0010, 1'b0, 1'b1, 16'h1234, 0);
        do_req(16'h0010, 1'b1, 1'b0, 16'h0000, 0);
        drain();

        // I/O read with three wait cycles
        do_req(16'hFF03, 1'b0, 1'b1, 16'hBEEF, 0);
        do_req(16'hFF03, 1'b1, 1'b0, 16'h0000, 3);
        for (int i = 0; i < 4; i++) begin
            chk("io_rd_held", 32'(o_io_rd), 32'd1);
            chk("io_addr", 32'(o_io_addr), 32'd3);
            @(posedge clk); #1;
        end
        chk("io_rd_released", 32'(o_io_rd), 32'd0);
        drain();

        // Unmapped read and write
        do_req(16'h8000, 1'b1, 1'b0, 16'h0000, 0);
        drain();
        do_req(16'h8000, 1'b0, 1'b1, 16'h5555, 0);
        chk("unmapped_wr_no_wait", 32'(o_cpu_wait), 32'd0);

        // rd and wr together act as a RAM write
        do_req(16'h0020, 1'b1, 1'b1, 16'h00AA, 0);
        chk("rdwr_no_wait", 32'(o_cpu_wait), 32'd0);
        do_req(16'h0020, 1'b1, 1'b0, 16'h0000, 0);
        drain();

        // Reset while an I/O access is stalled
        do_req(16'hFF05, 1'b1, 1'b0, 16'h0000, 1000);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("reset_midop_outputs_zero", 32'(any_output()), 32'd0);
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        do_req(16'hFF05, 1'b1, 1'b0, 16'h0000, 2);
        drain();

`ifdef IO_TIMEOUT_EN
        // Stuck I/O slave: read and write both abort
        chk("bus_err_before", 32'(o_bus_err), 32'd0);
        do_req(16'hFF07, 1'b1, 1'b0, 16'h0000, 1000);
        drain();
        chk("bus_err_set", 32'(o_bus_err), 32'd1);
        do_req(16'hFF08, 1'b0, 1'b1, 16'h7777, 1000);
        drain();
        do_req(16'hFF08, 1'b1, 1'b0, 16'h0000, 0);
        drain();
        chk("bus_err_sticky", 32'(o_bus_err), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("bus_err_cleared", 32'(o_bus_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
`endif

        // Randomised traffic over RAM pool, I/O block and unmapped edges
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                k    = $urandom_range(0, 31);
                addr = (k < 16) ? 16'(k) : 16'(4080 + k - 16);
            end else if (r < 8) begin
                addr = 16'hFF00 + 16'($urandom_range(0, 15));
            end else begin
                k    = $urandom_range(0, 7);
                addr = (k < 7) ? unm_tab[k] : 16'($urandom_range(16'h1000, 16'hFEFF));
            end
            k = $urandom_range(0, 3);
            do_req(addr, (k != 2), (k >= 2), 16'($urandom), $urandom_range(0, 4));
        end
        drain();
        repeat (3) @(posedge clk); #1;
        chk("bus_err_final", 32'(o_bus_err), 32'd0);
        finish_sim();
    end

endmodule
